// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet framing constants and transmit state type.
package eth_pkg;
   localparam int ETH_HDR_LEN = 14;
   localparam int ETH_MIN_PAYLOAD = 46;
   localparam int ETH_MAX_PAYLOAD = 1500;
   localparam logic [15:0] ETH_TYPE_DEFAULT = 16'h88B5;
   typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, PAD, DROP} eth_tx_state_t;
endpackage

// File: rtl/eth_tx_hdr_sel.sv
// eth_tx_hdr_sel: picks header byte[idx] from DST_MAC/SRC_MAC/ETHERTYPE, MSB byte first.
module eth_tx_hdr_sel import eth_pkg::*; #(
   parameter logic [47:0] DST_MAC = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] SRC_MAC = 48'h02_00_00_00_00_01,
   parameter logic [15:0] ETHERTYPE = ETH_TYPE_DEFAULT
) (
   input  logic [3:0] idx,
   output logic [7:0] hdr_byte
);
   localparam logic [111:0] HDR_BITS = {DST_MAC, SRC_MAC, ETHERTYPE};
   logic [7:0] shift;
   logic [111:0] shifted;
   assign shift = 8'd104 - {1'b0, idx, 3'b000};
   assign shifted = HDR_BITS >> shift;
   assign hdr_byte = (idx > 4'(ETH_HDR_LEN - 1)) ? 8'h00 : shifted[7:0];
endmodule

// File: rtl/ethernet_frame_tx.sv
// ethernet_frame_tx: wraps a payload stream into header + payload + zero pad frames,
// truncating oversize payloads and flagging them with tx_user on the last byte.
module ethernet_frame_tx import eth_pkg::*; #(
   parameter logic [47:0] DST_MAC = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] SRC_MAC = 48'h02_00_00_00_00_01,
   parameter logic [15:0] ETHERTYPE = ETH_TYPE_DEFAULT,
   parameter int MAX_PAYLOAD = ETH_MAX_PAYLOAD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic        s_last,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        tx_last,
   output logic        tx_user,
   output logic [15:0] frames_sent,
   output logic [15:0] frames_trunc
);
   eth_tx_state_t state;
   logic [3:0] hdr_idx;
   logic [10:0] pay_cnt, pay_nxt;
   logic [7:0] hdr_byte;
   logic acc, at_min, at_max, in_pay;
   eth_tx_hdr_sel #(.DST_MAC(DST_MAC), .SRC_MAC(SRC_MAC), .ETHERTYPE(ETHERTYPE)) u_hdr (
      .idx(hdr_idx),
      .hdr_byte(hdr_byte)
   );
   assign pay_nxt = pay_cnt + 11'd1;
   assign at_min = pay_nxt >= 11'(ETH_MIN_PAYLOAD);
   assign at_max = pay_nxt == 11'(MAX_PAYLOAD);
   assign in_pay = state == PAYLOAD;
   // PAYLOAD is a combinational pass-through so the stream keeps full throughput
   assign tx_valid = state == HDR || state == PAD || (in_pay && s_valid);
   assign s_ready = state == DROP || (in_pay && tx_ready);
   assign tx_data = state == HDR ? hdr_byte : in_pay ? s_data : 8'h00;
   assign tx_last = (state == PAD && at_min) || (in_pay && (s_last ? at_min : at_max));
   assign tx_user = in_pay && !s_last && at_max;
   assign acc = tx_valid && tx_ready;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         hdr_idx <= '0;
         pay_cnt <= '0;
         frames_sent <= '0;
         frames_trunc <= '0;
      end else begin
         if (acc && tx_last) frames_sent <= frames_sent + 16'd1;
         case (state)
            IDLE: if (s_valid) begin
               state <= HDR;
               hdr_idx <= '0;
               pay_cnt <= '0;
            end
            HDR: if (tx_ready) begin
               hdr_idx <= hdr_idx + 4'd1;
               if (hdr_idx == 4'(ETH_HDR_LEN - 1)) state <= PAYLOAD;
            end
            PAYLOAD: if (acc) begin
               pay_cnt <= pay_nxt;
               if (tx_user) begin
                  state <= DROP;
                  frames_trunc <= frames_trunc + 16'd1;
               end else if (tx_last) state <= IDLE;
               else if (s_last) state <= PAD;
            end
            PAD: if (tx_ready) begin
               pay_cnt <= pay_nxt;
               if (at_min) state <= IDLE;
            end
            DROP: if (s_valid && s_last) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/ethernet_frame_tx.md
# ethernet_frame_tx

Ethernet transmit framer: the outbound counterpart of the receive-side parser. It takes a raw payload byte stream from the datatape core and emits complete frames to the MAC TX byte interface: 14-byte header, payload, and zero padding to the 46-byte minimum. It also truncates oversize payloads. The MAC appends preamble and FCS; this block never generates them.

## Interface
Parameters:
- DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC address; header bytes 0–5, MSB byte first
- SRC_MAC, 48'h02_00_00_00_00_01, source MAC address; header bytes 6–11, MSB byte first
- ETHERTYPE, 16'h88B5, EtherType; header byte 12 = [15:8], byte 13 = [7:0]
- MAX_PAYLOAD, 1500, maximum payload bytes per frame

Ports:
- clk  in  1  Ethernet clock, 125 MHz; single clock domain. Reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset
- s_data  in  8  payload byte
- s_valid  in  1  payload byte valid
- s_ready  out  1  payload byte accepted when s_valid && s_ready
- s_last  in  1  last payload byte of the frame
- tx_data  out  8  byte to MAC
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  MAC accepts the byte when tx_valid && tx_ready
- tx_last  out  1  final byte of the frame
- tx_user  out  1  frame error flag; asserted only with tx_last on a truncated frame
- frames_sent  out  16  count of frames completed, i.e. tx_last accepted; wraps
- frames_trunc  out  16  count of truncated frames; wraps

## Operation
- States: IDLE, HDR, PAYLOAD, PAD, DROP.
- IDLE: tx_valid=0, s_ready=0. When s_valid=1, go to HDR; no byte is consumed. Set hdr_idx=0 and pay_cnt=0.
- HDR: tx_valid=1, tx_data=header byte[hdr_idx], s_ready=0. hdr_idx increments on each accept. When byte 13 is accepted, go to PAYLOAD.
- PAYLOAD: pass-through. tx_data=s_data, tx_valid=s_valid, s_ready=tx_ready (combinational). pay_cnt (11 bits) increments on each accept.
  - Accept with s_last=1 and pay_cnt+1 ≥ 46: tx_last=1 on that byte; go to IDLE.
  - Accept with s_last=1 and pay_cnt+1 < 46: tx_last=0; go to PAD.
  - Accept with s_last=0 and pay_cnt+1 == MAX_PAYLOAD: that byte carries tx_last=1 and tx_user=1; go to DROP.
  - Accept with s_last=1 and pay_cnt+1 == MAX_PAYLOAD: normal end, tx_user=0.
- PAD: tx_data=8'h00, tx_valid=1, s_ready=0. Emit until total payload reaches 46; the 46th byte carries tx_last=1. Then go to IDLE.
- DROP: tx_valid=0, s_ready=1. Discard input until s_last is accepted, then go to IDLE. frames_trunc increments on entry to DROP.
- frames_sent increments on every accepted byte with tx_last=1, including truncated frames.
- A zero-length payload is impossible: a frame always contains at least the byte carrying s_last.
- s_last arriving while in DROP with s_valid=1 is consumed in DROP; it never starts a new frame.

## Timing
- Reset values: state=IDLE, tx_valid=0, tx_last=0, tx_user=0, tx_data=8'h00, s_ready=0, hdr_idx=0, pay_cnt=0, frames_sent=0, frames_trunc=0.
- Reset mid-frame aborts the frame immediately. No tx_last is emitted; the MAC discards the partial frame.
- tx_data, tx_last and tx_user are stable while tx_valid && !tx_ready in HDR and PAD.
- In PAYLOAD, stability follows the upstream AXI-stream rule: s_data and s_last are held while s_valid && !s_ready.
- Latency: the first header byte is valid on the cycle after s_valid is first sampled high in IDLE.
- Gap: at least one IDLE cycle with tx_valid=0 between frames.
- Throughput: one byte per cycle when tx_ready is held high.
- Minimum frame: 14 + 46 = 60 bytes to the MAC.
- Maximum frame: 14 + MAX_PAYLOAD bytes to the MAC.

## Structure
- Shared package eth_pkg holds:
  - ETH_HDR_LEN=14, ETH_MIN_PAYLOAD=46, ETH_MAX_PAYLOAD=1500
  - the default EtherType 16'h88B5
  - the state enum eth_tx_state_t
- One sub-module, eth_tx_hdr_sel: combinational select of header byte[hdr_idx] from DST_MAC/SRC_MAC/ETHERTYPE. Output is 8'h00 for hdr_idx > 13.

## Test plan
- 100-byte payload 0x00..0x63 with tx_ready=1 → 114 bytes out: FF×6, 02 00 00 00 00 01, 88 B5, then 00..63; tx_last only on byte 113; tx_user=0; frames_sent=1.
- 10-byte payload 0xA0..0xA9 → 60 bytes out: header, A0..A9, 36×00; tx_last on byte 59 only.
- 1600-byte payload with MAX_PAYLOAD=1500 → 1514 bytes out; byte 1513 has tx_last=1 and tx_user=1; the remaining 100 input bytes are consumed with tx_valid=0; frames_trunc=1, frames_sent=1.
- Random tx_ready (50%) on a 46-byte payload → output identical to the tx_ready=1 run; tx_data held stable during every stall; no pad bytes emitted.
- rst asserted at header byte 5 → next cycle tx_valid=0 and all counters 0; a following 46-byte frame is emitted intact.
- Back-to-back frames with s_valid held high → at least one tx_valid=0 cycle between frames; second header starts with FF; frames_sent=2.
